// File: rtl/dot_product_accumulator_if.sv
// Handshake bundle for dot_product_accumulator.
// Carries the product stream (in_valid/in_ready/in_data) and the result stream
// (out_valid/out_ready/out_data).
//   master : producer of products and consumer of results (the surrounding datapath)
//   slave  : the accumulator itself
interface dot_product_accumulator_if #(
  parameter int unsigned PROD_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 20
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PROD_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums each group of VEC_LEN unsigned products into one dot-product result.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of dot_product_accumulator_if
//          in_valid/in_ready/in_data    product stream (accept = in_valid & in_ready)
//          out_valid/out_ready/out_data result stream (release = out_valid & out_ready)
// Groups end by count only. A result is held until released; in_ready bypasses
// out_ready so a new vector can start in the same cycle the previous result leaves.
module dot_product_accumulator #(
  parameter int unsigned PROD_WIDTH = 16,
  parameter int unsigned VEC_LEN    = 10,
  parameter int unsigned ACC_WIDTH  = 20
) (
  input logic                      clk,
  input logic                      rst,
  dot_product_accumulator_if.slave bus
);

  localparam int unsigned CNT_WIDTH = $clog2(VEC_LEN + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(VEC_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                state;
  logic [ACC_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [ACC_WIDTH-1:0]  result;
  logic                  result_valid;

  logic                  accept;
  logic                  do_release;
  logic                  finish;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  sum;

  assign bus.in_ready  = (state != StHold) | bus.out_ready;
  assign bus.out_valid = result_valid;
  assign bus.out_data  = result;

  assign accept     = bus.in_valid & bus.in_ready;
  assign do_release = result_valid & bus.out_ready;
  assign prod_ext   = ACC_WIDTH'(bus.in_data);
  // acc is zero outside StAccum, so sum also covers the first beat of a vector.
  assign sum        = acc + prod_ext;
  // With VEC_LEN == 1 every accepted beat completes a group.
  assign finish     = accept & ((VEC_LEN == 1) | ((state == StAccum) & (cnt == LAST_CNT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      acc          <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (finish) begin
            result       <= sum;
            result_valid <= 1'b1;
            acc          <= '0;
            cnt          <= '0;
            state        <= StHold;
          end else if (accept) begin
            acc   <= prod_ext;
            cnt   <= ONE_CNT;
            state <= StAccum;
          end
        end
        StAccum: begin
          if (finish) begin
            result       <= sum;
            result_valid <= 1'b1;
            acc          <= '0;
            cnt          <= '0;
            state        <= StHold;
          end else if (accept) begin
            acc <= sum;
            cnt <= cnt + ONE_CNT;
          end
        end
        StHold: begin
          // In StHold an accept implies a release (in_ready == out_ready here).
          if (finish) begin
            result <= sum;
          end else if (accept) begin
            result_valid <= 1'b0;
            acc          <= prod_ext;
            cnt          <= ONE_CNT;
            state        <= StAccum;
          end else if (do_release) begin
            result_valid <= 1'b0;
            state        <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
